// File: rtl/asic_io_page_ctrl.sv
// Z80 I/O-write sequencer for the CPC expansion CPLD: filters IORQ/WR, emits one
// &BCxx strobe per accepted write cycle and owns the RMR2 register behind port &7Fxx.
//
// state | meaning
// IDLE  | waiting for synchronised ioreq_b and wr_b both low
// QUAL  | counting consecutive low clocks up to MIN_LOW
// CAPT  | one clock: sample adr_hi/data/enf and decode the write
// HOLD  | action done, wait for ioreq_b to go high
module asic_io_page_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LOW     = 2
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       ioreq_b,
    input  logic       wr_b,
    input  logic [7:0] adr_hi,
    input  logic [7:0] data,
    input  logic       enf,
    output logic       bc_wr_stb,
    output logic [7:0] bc_data,
    output logic [7:0] rmr2_q,
    output logic       asic_page_en,
    output logic [2:0] lorom_sel,
    output logic [1:0] lorom_loc
);

    typedef enum logic [1:0] {IDLE, QUAL, CAPT, HOLD} state_t;

    localparam logic [2:0] LAST_CNT = 3'(MIN_LOW - 1);

    state_t                 state, state_nx;
    logic [2:0]             count, count_nx;
    logic [SYNC_STAGES-1:0] ioreq_sync, wr_sync;
    logic                   ioreq_s, wr_s, both_low;
    logic                   bc_hit, rmr2_hit;

    // Synchronisers reset high so a cycle in flight at reset release is seen as new.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ioreq_sync <= '1;
            wr_sync    <= '1;
        end else begin
            ioreq_sync <= {ioreq_sync[SYNC_STAGES-2:0], ioreq_b};
            wr_sync    <= {wr_sync[SYNC_STAGES-2:0], wr_b};
        end
    end

    assign ioreq_s  = ioreq_sync[SYNC_STAGES-1];
    assign wr_s     = wr_sync[SYNC_STAGES-1];
    assign both_low = !ioreq_s && !wr_s;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
            count <= 3'd0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        case (state)
            IDLE: begin
                if (both_low) begin
                    count_nx = 3'd1;
                    state_nx = (MIN_LOW == 1) ? CAPT : QUAL;
                end
            end
            QUAL: begin
                if (!both_low) begin
                    state_nx = IDLE;
                    count_nx = 3'd0;
                end else if (count == LAST_CNT) begin
                    state_nx = CAPT;
                    count_nx = count + 3'd1;
                end else begin
                    count_nx = count + 3'd1;
                end
            end
            CAPT: begin
                state_nx = HOLD;
                count_nx = 3'd0;
            end
            HOLD: begin
                if (ioreq_s) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                count_nx = 3'd0;
            end
        endcase
    end

    always_comb begin
        bc_hit   = 1'b0;
        rmr2_hit = 1'b0;
        if (state == CAPT) begin
            bc_hit   = (adr_hi == 8'hBC);
            rmr2_hit = (adr_hi == 8'h7F) && (data[7:5] == 3'b101) && enf;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            bc_wr_stb <= 1'b0;
            bc_data   <= 8'h00;
            rmr2_q    <= 8'h00;
        end else begin
            bc_wr_stb <= bc_hit;
            if (bc_hit)   bc_data <= data;
            if (rmr2_hit) rmr2_q  <= data;
        end
    end

    // enf gates the page directly so the ASIC page vanishes the moment features lock.
    assign asic_page_en = enf && (rmr2_q[4:3] == 2'b11);
    assign lorom_loc    = rmr2_q[4:3];
    assign lorom_sel    = rmr2_q[2:0];

endmodule

// File: tb/tb_asic_io_page_ctrl.sv
// Scoreboard bench for asic_io_page_ctrl: expected strobes are queued as writes are
// driven and matched (data and arrival clock) when bc_wr_stb appears.
module tb_asic_io_page_ctrl;

    logic       clk = 1'b0;
    logic       reset_b;
    logic       ioreq_b;
    logic       wr_b;
    logic [7:0] adr_hi;
    logic [7:0] data;
    logic       enf;
    logic       bc_wr_stb;
    logic [7:0] bc_data;
    logic [7:0] rmr2_q;
    logic       asic_page_en;
    logic [2:0] lorom_sel;
    logic [1:0] lorom_loc;

    typedef struct {
        logic [7:0] dat;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam int LATENCY = 5;

    asic_io_page_ctrl dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .ioreq_b      (ioreq_b),
        .wr_b         (wr_b),
        .adr_hi       (adr_hi),
        .data         (data),
        .enf          (enf),
        .bc_wr_stb    (bc_wr_stb),
        .bc_data      (bc_data),
        .rmr2_q       (rmr2_q),
        .asic_page_en (asic_page_en),
        .lorom_sel    (lorom_sel),
        .lorom_loc    (lorom_loc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Strobe monitor: every pulse must match the oldest queued write; a held or
    // extra pulse finds the queue empty.
    always @(negedge clk) begin
        exp_t e;
        if (reset_b && bc_wr_stb) begin
            if (sb.size() == 0) begin
                chk("spurious_stb", 32'(bc_wr_stb), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("bc_data", 32'(bc_data), 32'(e.dat));
                chk("stb_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic io_wr(input logic [7:0] adr, input logic [7:0] dat,
                         input int low_clks, input bit exp_stb);
        @(negedge clk);
        adr_hi  = adr;
        data    = dat;
        ioreq_b = 1'b0;
        wr_b    = 1'b0;
        if (exp_stb) sb.push_back('{dat, cyc + LATENCY});
        repeat (low_clks) @(negedge clk);
        ioreq_b = 1'b1;
        wr_b    = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    logic [7:0] seq [17] = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                             8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE};

    initial begin
        reset_b = 1'b0;
        ioreq_b = 1'b1;
        wr_b    = 1'b1;
        adr_hi  = 8'h00;
        data    = 8'h00;
        enf     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stb", 32'(bc_wr_stb), 32'd0);
        chk("rst_rmr2", 32'(rmr2_q), 32'h00);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_stb", 32'(bc_wr_stb), 32'd0);
        chk("idle_bc_data", 32'(bc_data), 32'h00);
        chk("idle_rmr2", 32'(rmr2_q), 32'h00);
        chk("idle_page", 32'(asic_page_en), 32'd0);
        chk("idle_sel", 32'(lorom_sel), 32'd0);
        chk("idle_loc", 32'(lorom_loc), 32'd0);

        io_wr(8'hBC, 8'hFF, 8, 1'b1);

        io_wr(8'hBC, 8'h3C, 1, 1'b0);
        chk("glitch_rmr2", 32'(rmr2_q), 32'h00);
        io_wr(8'hBC, 8'h42, 8, 1'b1);

        io_wr(8'hBC, 8'hA5, 40, 1'b1);

        for (int i = 0; i < 17; i++) io_wr(8'hBC, seq[i], 6, 1'b1);

        enf = 1'b0;
        io_wr(8'h7F, 8'hB9, 8, 1'b0);
        chk("locked_rmr2", 32'(rmr2_q), 32'h00);
        chk("locked_page", 32'(asic_page_en), 32'd0);

        enf = 1'b1;
        io_wr(8'h7F, 8'hB9, 8, 1'b0);
        chk("unlk_rmr2", 32'(rmr2_q), 32'hB9);
        chk("unlk_page", 32'(asic_page_en), 32'd1);
        chk("unlk_loc", 32'(lorom_loc), 32'd3);
        chk("unlk_sel", 32'(lorom_sel), 32'd1);

        @(negedge clk);
        enf = 1'b0;
        #1;
        chk("enf_drop_page", 32'(asic_page_en), 32'd0);
        chk("enf_drop_rmr2", 32'(rmr2_q), 32'hB9);

        enf = 1'b1;
        io_wr(8'h7F, 8'h8C, 8, 1'b0);
        chk("rmr_not_rmr2", 32'(rmr2_q), 32'hB9);
        chk("page_back", 32'(asic_page_en), 32'd1);
        io_wr(8'h7E, 8'hA0, 8, 1'b0);
        chk("other_port", 32'(rmr2_q), 32'hB9);
        io_wr(8'h7F, 8'hA6, 8, 1'b0);
        chk("rmr2_rewrite", 32'(rmr2_q), 32'hA6);
        chk("rewrite_sel", 32'(lorom_sel), 32'd6);
        chk("rewrite_loc", 32'(lorom_loc), 32'd0);
        chk("rewrite_page", 32'(asic_page_en), 32'd0);

        // Reset while the FSM sits in HOLD after a strobe.
        @(negedge clk);
        adr_hi  = 8'hBC;
        data    = 8'h5A;
        ioreq_b = 1'b0;
        wr_b    = 1'b0;
        sb.push_back('{8'h5A, cyc + LATENCY});
        repeat (7) @(negedge clk);
        reset_b = 1'b0;
        #1;
        chk("midrst_rmr2", 32'(rmr2_q), 32'h00);
        chk("midrst_stb", 32'(bc_wr_stb), 32'd0);
        chk("midrst_bc_data", 32'(bc_data), 32'h00);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        ioreq_b = 1'b1;
        wr_b    = 1'b1;
        repeat (6) @(negedge clk);
        chk("postrst_rmr2", 32'(rmr2_q), 32'h00);

        io_wr(8'hBC, 8'hC3, 8, 1'b1);

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
